// File: rtl/modulo_debounce_pulso_pkg.sv
// Shared constants and types for the push-button conditioner.
// Also holds the channel map used by the sealing-controller top level.
package modulo_debounce_pulso_pkg;

    localparam int unsigned DEF_STABLE_COUNT  = 16;
    localparam int unsigned DEF_REPEAT_DELAY  = 32;
    localparam int unsigned DEF_REPEAT_PERIOD = 8;

    localparam int unsigned CH_ROLHAS = 0;
    localparam int unsigned CH_OP     = 1;

    typedef enum logic [1:0] {
        EV_IDLE,
        EV_PRESS,
        EV_HOLD,
        EV_RELEASE
    } lvl_evt_e;

    // Wide enough to hold DELAY+PERIOD without wrapping.
    function automatic int unsigned rcnt_width(input int unsigned delay,
                                               input int unsigned period);
        return $clog2(delay + period) + 1;
    endfunction

endpackage

// File: rtl/modulo_debounce_pulso_canal.sv
// One button channel: 2-FF synchroniser, stability filter,
// registered press pulse and optional auto-repeat.
module modulo_debounce_canal
    import modulo_debounce_pulso_pkg::*;
#(
    parameter int unsigned STABLE_COUNT  = DEF_STABLE_COUNT,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    input  logic inhibit_i,
    output logic level_o,
    output logic pulse_o
);

    localparam int unsigned CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_COUNT - 1);

    logic          s1_q, s2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rep_hit;
    lvl_evt_e      ev;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (s2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = s2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_comb begin
        ev = EV_IDLE;
        if (!level_q && level_d) begin
            ev = EV_PRESS;
        end else if (level_q && !level_d) begin
            ev = EV_RELEASE;
        end else if (level_q) begin
            ev = EV_HOLD;
        end
    end

    if (REPEAT_EN != 0) begin : g_rep
        localparam int unsigned RW = rcnt_width(REPEAT_DELAY, REPEAT_PERIOD);
        localparam logic [RW-1:0] R_FIRST = RW'(REPEAT_DELAY);
        localparam logic [RW-1:0] R_NEXT  = RW'(REPEAT_DELAY + REPEAT_PERIOD);

        logic [RW-1:0] rcnt_q, rcnt_d, rinc;

        // Held inhibit keeps rcnt at 0, so repeats count from the release edge.
        always_comb begin
            rinc    = (rcnt_q == '1) ? rcnt_q : rcnt_q + RW'(1);
            rcnt_d  = '0;
            rep_hit = 1'b0;
            if (!inhibit_i && ev == EV_HOLD) begin
                if (rinc == R_NEXT) begin
                    rcnt_d  = R_FIRST;
                    rep_hit = 1'b1;
                end else begin
                    rcnt_d  = rinc;
                    rep_hit = (rinc == R_FIRST);
                end
            end
        end

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                rcnt_q <= '0;
            end else begin
                rcnt_q <= rcnt_d;
            end
        end
    end else begin : g_norep
        assign rep_hit = 1'b0;
    end

    assign pulse_d = !inhibit_i && (ev == EV_PRESS || rep_hit);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            s1_q    <= raw_i;
            s2_q    <= s1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
        end
    end

    assign level_o = level_q;
    assign pulse_o = pulse_q;

endmodule

// File: rtl/modulo_debounce_pulso.sv
// Multi-channel push-button conditioner: polarity fix-up at the input
// and one independent debounce/pulse channel per button.
module modulo_debounce_pulso
    import modulo_debounce_pulso_pkg::*;
#(
    parameter int unsigned N_CANAIS      = 2,
    parameter int unsigned STABLE_COUNT  = DEF_STABLE_COUNT,
    parameter int unsigned ACTIVE_LOW    = 1,
    parameter int unsigned REPEAT_EN     = 0,
    parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic                clk,
    input  logic                clr,
    input  logic [N_CANAIS-1:0] btn_in,
    input  logic [N_CANAIS-1:0] inhibit,
    output logic [N_CANAIS-1:0] level_out,
    output logic [N_CANAIS-1:0] pulse_out
);

    logic [N_CANAIS-1:0] raw;

    assign raw = btn_in ^ {N_CANAIS{ACTIVE_LOW != 0}};

    for (genvar g = 0; g < N_CANAIS; g++) begin : g_canal
        modulo_debounce_canal #(
            .STABLE_COUNT (STABLE_COUNT),
            .REPEAT_EN    (REPEAT_EN),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_canal (
            .clk_i    (clk),
            .rst_i    (clr),
            .raw_i    (raw[g]),
            .inhibit_i(inhibit[g]),
            .level_o  (level_out[g]),
            .pulse_o  (pulse_out[g])
        );
    end

endmodule
